// File: rtl/user_obi_cnt.sv
// OBI subordinate timer/counter: prescaled up-counter with compare match,
// sticky W1C status and a level interrupt.

package croc_pkg;
    localparam int unsigned SbrIdWidth = 3;

    typedef struct packed {
        logic [31:0]           addr;
        logic                  we;
        logic [3:0]            be;
        logic [31:0]           wdata;
        logic [SbrIdWidth-1:0] aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        sbr_obi_a_chan_t a;
        logic            req;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [31:0]           rdata;
        logic [SbrIdWidth-1:0] rid;
        logic                  err;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        sbr_obi_r_chan_t r;
        logic            gnt;
        logic            rvalid;
    } sbr_obi_rsp_t;
endpackage

module user_obi_cnt #(
    parameter int unsigned CntWidth   = 32,
    parameter int unsigned PrescWidth = 16,
    parameter type         obi_req_t  = croc_pkg::sbr_obi_req_t,
    parameter type         obi_rsp_t  = croc_pkg::sbr_obi_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o,
    output logic     irq_o
);

    localparam int unsigned CtrlWidth = 3;

    logic [CtrlWidth-1:0]  ctrl_q, ctrl_d;
    logic [PrescWidth-1:0] presc_val_q, presc_val_d;
    logic [PrescWidth-1:0] presc_q, presc_d;
    logic [CntWidth-1:0]   cmp_q, cmp_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  match_q, match_d;
    logic                  irq_q, irq_d;
    obi_rsp_t              rsp_q, rsp_d;

    logic [2:0] off;
    logic       wr, bad, tick, hit;
    logic       unused_addr;

    function automatic logic [31:0] be_merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
        end
        return res;
    endfunction

    assign off         = obi_req_i.a.addr[4:2];
    assign unused_addr = ^{obi_req_i.a.addr[31:5], obi_req_i.a.addr[1:0]};
    assign bad         = (off > 3'd4);
    assign wr          = obi_req_i.req & obi_req_i.a.we & ~bad;
    assign tick        = ctrl_q[0] & (presc_q == presc_val_q);
    assign hit         = tick & (cnt_q == cmp_q);

    // Next state: prescaler and counter first, software writes override.
    always_comb begin
        ctrl_d      = ctrl_q;
        presc_val_d = presc_val_q;
        cmp_d       = cmp_q;
        cnt_d       = cnt_q;
        match_d     = match_q;
        presc_d     = presc_q;
        rsp_d       = '0;

        if (!ctrl_q[0] || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PrescWidth'(1);
        end

        if (tick) begin
            cnt_d = (hit && ctrl_q[1]) ? '0 : cnt_q + CntWidth'(1);
        end
        if (hit) begin
            match_d = 1'b1;
        end

        if (wr) begin
            case (off)
                3'd0: begin
                    ctrl_d  = CtrlWidth'(be_merge(32'(ctrl_q), obi_req_i.a.wdata, obi_req_i.a.be));
                    presc_d = '0;
                end
                3'd1: begin
                    presc_val_d = PrescWidth'(be_merge(32'(presc_val_q), obi_req_i.a.wdata,
                                                       obi_req_i.a.be));
                    presc_d     = '0;
                end
                3'd2: cmp_d = CntWidth'(be_merge(32'(cmp_q), obi_req_i.a.wdata, obi_req_i.a.be));
                3'd3: cnt_d = CntWidth'(be_merge(32'(cnt_q), obi_req_i.a.wdata, obi_req_i.a.be));
                3'd4: begin
                    // A match set in the same cycle beats the W1C clear.
                    if (obi_req_i.a.be[0] && obi_req_i.a.wdata[0] && !hit) begin
                        match_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        rsp_d.rvalid = obi_req_i.req;
        rsp_d.r.rid  = obi_req_i.a.aid;
        rsp_d.r.err  = obi_req_i.req & bad;
        if (obi_req_i.req && !obi_req_i.a.we && !bad) begin
            case (off)
                3'd0:    rsp_d.r.rdata = 32'(ctrl_q);
                3'd1:    rsp_d.r.rdata = 32'(presc_val_q);
                3'd2:    rsp_d.r.rdata = 32'(cmp_q);
                3'd3:    rsp_d.r.rdata = 32'(cnt_q);
                3'd4:    rsp_d.r.rdata = 32'(match_q);
                default: rsp_d.r.rdata = '0;
            endcase
        end

        irq_d = match_d & ctrl_d[2];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ctrl_q      <= '0;
            presc_val_q <= '0;
            presc_q     <= '0;
            cmp_q       <= '0;
            cnt_q       <= '0;
            match_q     <= 1'b0;
            irq_q       <= 1'b0;
            rsp_q       <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            presc_val_q <= presc_val_d;
            presc_q     <= presc_d;
            cmp_q       <= cmp_d;
            cnt_q       <= cnt_d;
            match_q     <= match_d;
            irq_q       <= irq_d;
            rsp_q       <= rsp_d;
        end
    end

    // Grant is the only combinational response field; it is held low in reset.
    always_comb begin
        obi_rsp_o     = rsp_q;
        obi_rsp_o.gnt = obi_req_i.req & rst_ni;
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_user_obi_cnt.sv
// Scoreboard bench for user_obi_cnt: directed scenarios plus random traffic
// checked against a register-level reference model.

module tb_user_obi_cnt;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned PRESC_W = 16;
    localparam int unsigned IDW     = croc_pkg::SbrIdWidth;
    localparam logic [31:0] CMASK   = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [31:0] PMASK   = 32'((64'd1 << PRESC_W) - 64'd1);

    typedef struct {
        logic [31:0]    rdata;
        logic           err;
        logic [IDW-1:0] rid;
        string          nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic irq;
    croc_pkg::sbr_obi_req_t req = '0;
    croc_pkg::sbr_obi_rsp_t rsp;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    // Reference model: architectural registers plus cycles elapsed since last tick.
    logic [31:0] m_ctrl = 0, m_presc = 0, m_cmp = 0, m_cnt = 0, m_phase = 0;
    bit          m_match = 0;
    bit          exp_irq = 0;

    user_obi_cnt #(.CntWidth(CNT_W), .PrescWidth(PRESC_W)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .obi_req_i(req),
        .obi_rsp_o(rsp),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r = (r & ~(32'hFF << (8 * i))) | (wd & (32'hFF << (8 * i)));
        end
        return r;
    endfunction

    task automatic model_step(input bit rq, input bit we, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wd, input logic [IDW-1:0] aid,
                              input bit use_k, input logic [31:0] k_rd, input bit k_err, input string nm);
        int          o = int'(addr[4:2]);
        bit          en = m_ctrl[0];
        bit          tick = en && (m_phase == m_presc);
        bit          is_match = tick && (m_cnt == m_cmp);
        bit          er = (o > 4);
        logic [31:0] rv = 0;
        logic [31:0] n_ctrl = m_ctrl, n_presc = m_presc, n_cmp = m_cmp, n_cnt = m_cnt, n_phase;
        bit          n_match = m_match;
        exp_t        e;

        if (rq) begin
            if (!we && !er) begin
                case (o)
                    0: rv = m_ctrl;
                    1: rv = m_presc;
                    2: rv = m_cmp;
                    3: rv = m_cnt;
                    default: rv = m_match ? 1 : 0;
                endcase
            end
            e.rdata = use_k ? k_rd : rv;
            e.err   = use_k ? k_err : er;
            e.rid   = aid;
            e.nm    = nm;
            sb.push_back(e);
        end

        if (tick) begin
            if (is_match) n_match = 1;
            n_cnt = (is_match && m_ctrl[1]) ? 0 : ((m_cnt + 1) & CMASK);
        end
        n_phase = (en && !tick) ? m_phase + 1 : 0;

        if (rq && we && !er) begin
            case (o)
                0: begin n_ctrl = merge(m_ctrl, wd, be) & 32'h7; n_phase = 0; end
                1: begin n_presc = merge(m_presc, wd, be) & PMASK; n_phase = 0; end
                2: n_cmp = merge(m_cmp, wd, be) & CMASK;
                3: n_cnt = merge(m_cnt, wd, be) & CMASK;
                default: if (be[0] && wd[0] && !is_match) n_match = 0;
            endcase
        end

        m_ctrl = n_ctrl; m_presc = n_presc; m_cmp = n_cmp; m_cnt = n_cnt;
        m_phase = n_phase; m_match = n_match;
        exp_irq = m_match && m_ctrl[2];
    endtask

    bit rst_want = 1'b0;

    task automatic cyc(input bit rq, input bit we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input bit use_k, input logic [31:0] k_rd,
                       input bit k_err, input string nm);
        logic [IDW-1:0] aid = IDW'($urandom);
        @(negedge clk);
        rst_ni      = rst_want;
        req.req     = rq;
        req.a.we    = we;
        req.a.addr  = addr;
        req.a.be    = be;
        req.a.wdata = wd;
        req.a.aid   = aid;
        if (!rst_ni) begin
            m_ctrl = 0; m_presc = 0; m_cmp = 0; m_cnt = 0; m_phase = 0; m_match = 0; exp_irq = 0;
        end else begin
            model_step(rq, we, addr, be, wd, aid, use_k, k_rd, k_err, nm);
        end
        #1;
        chk("gnt", 32'(rsp.gnt), 32'(rq && rst_ni));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        cyc(1, 1, a, be, d, 1'b0, 0, 1'b0, "wr");
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1, 0, a, 4'hF, $urandom, 1'b0, 0, 1'b0, "rd");
    endtask

    task automatic rdk(input logic [31:0] a, input logic [31:0] k, input bit kerr, input string nm);
        cyc(1, 0, a, 4'hF, $urandom, 1'b1, k, kerr, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 1'b0, 0, 1'b0, "idle");
    endtask

    // Monitor: one expected response per accepted request, due the next cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            chk("irq", 32'(irq), 32'(exp_irq));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.nm, "_rvalid"}, 32'(rsp.rvalid), 32'd1);
                chk({e.nm, "_rdata"}, rsp.r.rdata, e.rdata);
                chk({e.nm, "_err"}, 32'(rsp.r.err), 32'(e.err));
                chk({e.nm, "_rid"}, 32'(rsp.r.rid), 32'(e.rid));
            end else begin
                chk("no_rvalid", 32'(rsp.rvalid), 32'd0);
            end
        end
    end

    initial begin
        // Reset with a request held high.
        repeat (3) cyc(1, 0, 32'h0, 4'hF, 0, 1'b0, 0, 1'b0, "rst");
        rst_want = 1'b1;
        for (int i = 0; i < 5; i++) rdk(32'(4 * i), 0, 1'b0, "rst_rd");

        // Prescale 3: one count every 4 cycles.
        wr(32'h00, 0, 4'hF); wr(32'h04, 3, 4'hF); wr(32'h08, 32'hFFFF_FFFF, 4'hF);
        wr(32'h0C, 0, 4'hF); wr(32'h10, 1, 4'hF); wr(32'h00, 1, 4'hF);
        idle(40);
        rdk(32'h0C, 10, 1'b0, "cnt40");
        repeat (9) rd(32'h0C);

        // Match with clear-on-match and interrupt.
        wr(32'h00, 0, 4'hF); wr(32'h04, 0, 4'hF); wr(32'h08, 5, 4'hF);
        wr(32'h0C, 0, 4'hF); wr(32'h10, 1, 4'hF); wr(32'h00, 7, 4'hF);
        repeat (14) rd(32'h0C);
        wr(32'h10, 1, 4'hF);
        repeat (8) rd(32'h10);

        // W1C in the same cycle as a match tick.
        wr(32'h00, 0, 4'hF); wr(32'h04, 0, 4'hF); wr(32'h0C, 0, 4'hF);
        wr(32'h08, 3, 4'hF); wr(32'h10, 1, 4'hF); wr(32'h00, 5, 4'hF);
        idle(3);
        wr(32'h10, 1, 4'hF);
        rdk(32'h10, 1, 1'b0, "w1c_vs_set");
        // Software COUNT write on a tick cycle.
        wr(32'h0C, 32'h100, 4'hF);
        rdk(32'h0C, 32'h100, 1'b0, "cnt_wr_tick0");
        rdk(32'h0C, 32'h101, 1'b0, "cnt_wr_tick1");

        // Wrap-around without a match flag.
        wr(32'h00, 0, 4'hF); wr(32'h0C, 32'hFFFF_FFFE, 4'hF); wr(32'h08, 32'h10, 4'hF);
        wr(32'h04, 0, 4'hF); wr(32'h10, 1, 4'hF); wr(32'h00, 1, 4'hF);
        rdk(32'h0C, 32'hFFFF_FFFE, 1'b0, "wrap0");
        rdk(32'h0C, 32'hFFFF_FFFF, 1'b0, "wrap1");
        rdk(32'h0C, 32'h0, 1'b0, "wrap2");
        rdk(32'h0C, 32'h1, 1'b0, "wrap3");
        rdk(32'h10, 0, 1'b0, "wrap_status");

        // Byte strobes, aliased decode and error offsets.
        wr(32'h00, 0, 4'hF); wr(32'h08, 0, 4'hF);
        wr(32'h08, 32'hAABB_CCDD, 4'b0101);
        rdk(32'h08, 32'h00BB_00DD, 1'b0, "be_merge");
        rdk(32'h2000_000B, 32'h00BB_00DD, 1'b0, "addr_alias");
        rdk(32'h18, 0, 1'b1, "err_rd");
        cyc(1, 1, 32'h1C, 4'hF, 32'hFFFF_FFFF, 1'b1, 0, 1'b1, "err_wr");
        for (int i = 0; i < 5; i++) rd(32'(4 * i));

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a, d;
            logic [3:0]  be;
            a  = {$urandom_range(0, 7)} << 2 | ($urandom & 32'hFFFF_FFE3);
            d  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
            be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            if ($urandom_range(0, 3) == 0) idle(1);
            else cyc(1, 1'($urandom), a, be, d, 1'b0, 0, 1'b0, "rnd");
        end

        idle(2);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
